// File: rtl/sb_in_feed.sv
// Feeder for the masked S-box top linear layer: accepts one d-share 32-bit column, then emits it
// as four shared bytes. Defining SB_IN_FEED_REFRESH_EN re-masks the column with rnd on load.
module sb_in_feed #(
  parameter int unsigned d = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*d-1:0]       in_col,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*(d-1)-1:0]   rnd,
  output logic [d-1:0]          out_i7,
  output logic [d-1:0]          out_i6,
  output logic [d-1:0]          out_i5,
  output logic [d-1:0]          out_i4,
  output logic [d-1:0]          out_i3,
  output logic [d-1:0]          out_i2,
  output logic [d-1:0]          out_i1,
  output logic [d-1:0]          out_i0,
  output logic [1:0]            out_lane,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e            r_state, w_state_d;
  logic [1:0]        r_lane, w_lane_d;
  logic [32*d-1:0]   r_col, w_col_d, w_load_col;
  logic              w_load;
  logic [d-1:0][7:0] w_byte;

`ifdef SB_IN_FEED_REFRESH_EN
  // Last share absorbs every rnd word so the share-XOR of the column is unchanged.
  logic [31:0] w_rnd_sum;
  always_comb begin
    w_rnd_sum  = '0;
    w_load_col = in_col;
    for (int s = 0; s < int'(d) - 1; s++) begin
      w_rnd_sum                = w_rnd_sum ^ rnd[s*32 +: 32];
      w_load_col[s*32 +: 32]   = in_col[s*32 +: 32] ^ rnd[s*32 +: 32];
    end
    w_load_col[(d-1)*32 +: 32] = in_col[(d-1)*32 +: 32] ^ w_rnd_sum;
  end
`else
  logic w_unused_rnd;
  assign w_unused_rnd = ^rnd;
  assign w_load_col   = in_col;
`endif

  assign out_valid = (r_state == StSend);
  assign out_lane  = r_lane;
  assign out_last  = out_valid & (r_lane == 2'd3);
  assign in_ready  = (r_state == StIdle) | ((r_state == StSend) & (r_lane == 2'd3) & out_ready);
  assign w_load    = in_valid & in_ready;

  always_comb begin
    w_state_d = r_state;
    w_lane_d  = r_lane;
    w_col_d   = r_col;
    if (w_load) begin
      w_state_d = StSend;
      w_lane_d  = 2'd0;
      w_col_d   = w_load_col;
    end else if ((r_state == StSend) && out_ready) begin
      if (r_lane == 2'd3) begin
        w_state_d = StIdle;
        w_lane_d  = 2'd0;
      end else begin
        w_lane_d = r_lane + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_lane  <= 2'd0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_d;
      r_lane  <= w_lane_d;
      r_col   <= w_col_d;
    end
  end

  // Each share is muxed only against itself; outputs read zero while idle.
  always_comb begin
    for (int s = 0; s < int'(d); s++) begin
      w_byte[s] = out_valid ? r_col[s*32 + 8*int'(r_lane) +: 8] : 8'h00;
    end
  end

  for (genvar s = 0; s < int'(d); s++) begin : g_share
    assign out_i0[s] = w_byte[s][0];
    assign out_i1[s] = w_byte[s][1];
    assign out_i2[s] = w_byte[s][2];
    assign out_i3[s] = w_byte[s][3];
    assign out_i4[s] = w_byte[s][4];
    assign out_i5[s] = w_byte[s][5];
    assign out_i6[s] = w_byte[s][6];
    assign out_i7[s] = w_byte[s][7];
  end

endmodule

// File: tb/tb_sb_in_feed.sv
// Scoreboard bench for sb_in_feed: stimulus pushes expected shared bytes, a negedge monitor
// pops and compares them. Define SB_IN_FEED_REFRESH_EN to exercise the re-masking build (d=3).
module tb_sb_in_feed;
`ifdef SB_IN_FEED_REFRESH_EN
  localparam int D = 3;
  localparam bit REFRESH = 1'b1;
`else
  localparam int D = 2;
  localparam bit REFRESH = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [32*D-1:0]     in_col;
  logic                in_valid;
  logic                in_ready;
  logic [32*(D-1)-1:0] rnd;
  logic [D-1:0]        out_i7, out_i6, out_i5, out_i4, out_i3, out_i2, out_i1, out_i0;
  logic [1:0]          out_lane;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  always #5 clk = ~clk;

  sb_in_feed #(.d(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_col(in_col), .in_valid(in_valid), .in_ready(in_ready),
    .rnd(rnd), .out_i7(out_i7), .out_i6(out_i6), .out_i5(out_i5), .out_i4(out_i4),
    .out_i3(out_i3), .out_i2(out_i2), .out_i1(out_i1), .out_i0(out_i0), .out_lane(out_lane),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [7:0]        ub;
    logic [D-1:0][7:0] sh;
    logic [1:0]        lane;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [D-1:0][7:0] got_sh;
  always_comb begin
    for (int s = 0; s < D; s++) begin
      got_sh[s] = {out_i7[s], out_i6[s], out_i5[s], out_i4[s],
                   out_i3[s], out_i2[s], out_i1[s], out_i0[s]};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic logic [7:0] xsh(input logic [D-1:0][7:0] v);
    logic [7:0] r = 8'h00;
    for (int s = 0; s < D; s++) r ^= v[s];
    return r;
  endfunction

  function automatic logic [32*(D-1)-1:0] rand_rnd();
    logic [32*(D-1)-1:0] r;
    for (int s = 0; s < D - 1; s++) r[s*32 +: 32] = $urandom();
    return r;
  endfunction

  // Random masks in shares 1..D-1, share 0 chosen so the shares XOR to v.
  function automatic logic [32*D-1:0] mk_col(input logic [31:0] v);
    logic [32*D-1:0] c;
    logic [31:0]     acc = v;
    for (int s = 1; s < D; s++) begin
      c[s*32 +: 32] = $urandom();
      acc ^= c[s*32 +: 32];
    end
    c[31:0] = acc;
    return c;
  endfunction

  // Reference: what a loaded column must look like byte by byte.
  task automatic push_col(input logic [32*D-1:0] col, input logic [32*(D-1)-1:0] r);
    logic [32*D-1:0] lc = col;
    logic [31:0]     rs = 32'h0;
    exp_t            e;
    for (int s = 0; s < D - 1; s++) rs ^= r[s*32 +: 32];
    if (REFRESH) begin
      for (int s = 0; s < D - 1; s++) lc[s*32 +: 32] ^= r[s*32 +: 32];
      lc[(D-1)*32 +: 32] ^= rs;
    end
    for (int l = 0; l < 4; l++) begin
      e.ub = 8'h00;
      for (int s = 0; s < D; s++) begin
        e.sh[s] = lc[s*32 + 8*l +: 8];
        e.ub ^= col[s*32 + 8*l +: 8];
      end
      e.lane = 2'(l);
      exp_q.push_back(e);
    end
    lat_q.push_back(cyc + 1);
  endtask

  logic        prev_hold = 1'b0;
  logic        prev_fire_nl = 1'b0;
  logic        rst_seen = 1'b0;
  logic [63:0] snap = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      lat_q.delete();
      rst_seen     = 1'b1;
      prev_hold    = 1'b0;
      prev_fire_nl = 1'b0;
    end else begin
      if (rst_seen) begin
        chk("reset_out_valid", 64'(out_valid), 64'(1'b0));
        chk("reset_in_ready", 64'(in_ready), 64'(1'b1));
        chk("reset_out_lane", 64'(out_lane), 64'(2'd0));
        chk("reset_out_last", 64'(out_last), 64'(1'b0));
        chk("reset_out_bytes", 64'(got_sh), 64'(0));
        rst_seen = 1'b0;
      end
      if (prev_hold) chk("hold_stable", 64'({out_valid, out_last, out_lane, got_sh}), snap);
      if (prev_fire_nl) chk("burst_gap", 64'(out_valid), 64'(1'b1));
      if (out_valid && !prev_hold && out_lane == 2'd0) begin
        if (lat_q.size() == 0) fail_now("latency", "byte 0 presented with no column accepted");
        else chk("latency", 64'(cyc), 64'(lat_q.pop_front()));
      end
      chk("in_ready", 64'(in_ready), 64'(!out_valid || (out_lane == 2'd3 && out_ready)));
      chk("out_last", 64'(out_last), 64'(out_valid && out_lane == 2'd3));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_byte", $sformatf("got lane %0d, expected no byte", out_lane));
        end else begin
          e = exp_q.pop_front();
          chk("lane", 64'(out_lane), 64'(e.lane));
          chk("unmasked_byte", 64'(xsh(got_sh)), 64'(e.ub));
          chk("shares", 64'(got_sh), 64'(e.sh));
        end
      end
      if (in_valid && in_ready) push_col(in_col, rnd);
      prev_hold    = out_valid && !out_ready;
      snap         = 64'({out_valid, out_last, out_lane, got_sh});
      prev_fire_nl = out_valid && out_ready && (out_lane != 2'd3);
    end
  end

  task automatic send_col(input logic [32*D-1:0] col);
    int n = 0;
    in_col   = col;
    in_valid = 1'b1;
    rnd      = rand_rnd();
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("accept_timeout", "column not accepted within 50 cycles");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((out_valid || exp_q.size() != 0) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (out_valid || exp_q.size() != 0) fail_now("drain_timeout", "bytes still pending");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32*D-1:0] c;
    // T1: reset with in_valid high
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_col    = mk_col($urandom());
    rnd       = rand_rnd();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // T2: single column
    c        = '0;
    c[31:0]  = 32'hA1B2C3D4;
    send_col(c);
    in_valid = 1'b0;
    wait_idle();

    // T3: backpressure at lane 1 with another column waiting
    send_col(mk_col($urandom()));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    c         = mk_col($urandom());
    in_col    = c;
    in_valid  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_col(c);
    in_valid = 1'b0;
    wait_idle();

    // T4: back-to-back columns
    send_col(mk_col(32'h01234567));
    send_col(mk_col(32'h89ABCDEF));
    in_valid = 1'b0;
    wait_idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom() % 2) == 0;
      in_col    = mk_col($urandom());
      rnd       = rand_rnd();
      out_ready = ($urandom() % 4) != 0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // T5: reset while lane 2 is presented
    send_col(mk_col($urandom()));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("latency_queue_empty", 64'(lat_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
